// File: rtl/symbol_serializer.sv
// symbol_serializer: transmit side of the serial symbol link.
// Accepts 2-bit symbols over a valid/ready handshake and buffers them in a
// DEPTH-entry FIFO. Each symbol goes out on `x` as a prefix code, one bit per
// clock, MSB first:
//   0 -> "0", 1 -> "10", 2 -> "110", 3 -> "111".
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   sym_in     symbol to send (0..3)
//   sym_valid  sym_in is valid
//   sym_ready  FIFO can accept (combinational: !full && !reset)
//   pause      freezes the serializer; the FIFO still accepts pushes
//   x          serial code bit (registered)
//   x_valid    x carries a code bit this cycle (registered)
//   busy       x_valid || FIFO non-empty (combinational)
//   sym_count  symbols fully emitted, modulo 2^CNT_W (registered)
module symbol_serializer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             pause,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic [CNT_W-1:0] sym_count
);

  // Pointer carries one extra wrap bit so full and empty are distinguishable.
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // FIFO storage and pointers
  logic [1:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Serializer state
  state_e           state_q, state_d;
  logic [2:0]       shift_q, shift_d;
  logic [1:0]       rem_q, rem_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Head-of-FIFO code lookup
  logic [1:0] head_sym;
  logic [2:0] head_code;
  logic [1:0] head_len;

  // Full when the index bits match but the wrap bits differ.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Registered-full policy: a pop in the same cycle does not open the gate.
  assign sym_ready = !full && !reset;
  assign push      = sym_valid && sym_ready;

  assign wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

  // FIFO write port; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= sym_in;
    end
  end

  assign head_sym = mem_q[rd_ptr_q[AW-1:0]];

  // Prefix code left-aligned in 3 bits so bit 2 always leaves first.
  always_comb begin
    head_code = 3'b111;
    head_len  = 2'd3;
    case (head_sym)
      2'd0: begin
        head_code = 3'b000;
        head_len  = 2'd1;
      end
      2'd1: begin
        head_code = 3'b100;
        head_len  = 2'd2;
      end
      2'd2: begin
        head_code = 3'b110;
        head_len  = 2'd3;
      end
      default: begin
        head_code = 3'b111;
        head_len  = 2'd3;
      end
    endcase
  end

  // Next-state and output logic. rem counts bits still to send after the one
  // currently on x; IDLE <=> rem==0. When the last bit leaves (rem 1->0) the
  // FSM returns to IDLE and may pop the next symbol on the following edge,
  // giving gap-free back-to-back output.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    rem_d     = rem_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    cnt_d     = cnt_q;
    pop       = 1'b0;

    // Pause freezes shift/rem/read side and idles the line.
    if (!pause) begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            pop       = 1'b1;
            x_d       = head_code[2];
            x_valid_d = 1'b1;
            shift_d   = {head_code[1:0], 1'b0};
            rem_d     = head_len - 2'd1;
            if (head_len == 2'd1) begin
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              state_d = SEND;
            end
          end
        end
        SEND: begin
          x_d       = shift_q[2];
          x_valid_d = 1'b1;
          shift_d   = {shift_q[1:0], 1'b0};
          rem_d     = rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          rem_d   = 2'd0;
        end
      endcase
    end
  end

  // State registers; reset drops any partial symbol and all queued entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= 3'd0;
      rem_q     <= 2'd0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      rem_q     <= rem_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign sym_count = cnt_q;
  assign busy      = x_valid_q || !empty;

endmodule

// File: tb/tb_symbol_serializer.sv
// tb_symbol_serializer: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model of the symbol link.
module tb_symbol_serializer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       sym_in;
  logic             sym_valid;
  logic             sym_ready;
  logic             pause;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic [CNT_W-1:0] sym_count;

  always #5 clk = ~clk;

  symbol_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .pause     (pause),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .sym_count (sym_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queued symbols, pending bits of the symbol on the wire.
  int fifo_q[$];
  bit cur_q[$];
  bit m_x  = 1'b0;
  bit m_xv = 1'b0;
  int m_cnt = 0;

  // Observed serial bits since last clear
  bit obs[$];
  int cyc = 0;
  int first_cyc = -1;
  int last_cyc  = -1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Code of symbol s: s ones then a zero, except symbol 3 which is three ones.
  task automatic load_code(input int s);
    int len;
    len = (s == 0) ? 1 : (s == 1) ? 2 : 3;
    for (int k = 0; k < len; k++) begin
      cur_q.push_back((s == 3) ? 1'b1 : ((k < s) ? 1'b1 : 1'b0));
    end
  endtask

  task automatic emit();
    m_x  = cur_q.pop_front();
    m_xv = 1'b1;
    if (cur_q.size() == 0) m_cnt = (m_cnt + 1) % CNT_MOD;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    bit do_push;
    if (reset) begin
      fifo_q.delete();
      cur_q.delete();
      m_x   = 1'b0;
      m_xv  = 1'b0;
      m_cnt = 0;
      return;
    end
    do_push = sym_valid && (fifo_q.size() < DEPTH);
    if (pause) begin
      m_x  = 1'b0;
      m_xv = 1'b0;
    end else if (cur_q.size() == 0 && fifo_q.size() > 0) begin
      load_code(fifo_q.pop_front());
      emit();
    end else if (cur_q.size() > 0) begin
      emit();
    end else begin
      m_x  = 1'b0;
      m_xv = 1'b0;
    end
    if (do_push) fifo_q.push_back(int'(sym_in));
  endtask

  // One clock: check combinational outputs, advance, check registered outputs.
  task automatic step();
    #1;
    check_eq("sym_ready", 32'(sym_ready), 32'(!reset && (fifo_q.size() < DEPTH)));
    check_eq("busy", 32'(busy), 32'(m_xv || (fifo_q.size() > 0)));
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_eq("x_valid", 32'(x_valid), 32'(m_xv));
    check_eq("x", 32'(x), 32'(m_x));
    check_eq("sym_count", 32'(sym_count), 32'(m_cnt));
    if (x_valid === 1'b1) begin
      obs.push_back(x);
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
  endtask

  task automatic clr_obs();
    obs.delete();
    first_cyc = -1;
    last_cyc  = -1;
  endtask

  // Present a symbol and hold valid until the model says it was accepted.
  task automatic push_sym(input int s);
    bit done;
    bit acc;
    done = 1'b0;
    sym_valid = 1'b1;
    sym_in    = 2'(s);
    for (int t = 0; t < 200; t++) begin
      acc = !reset && (fifo_q.size() < DEPTH);
      step();
      if (acc) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_eq("push_timeout", 32'd0, 32'd1);
    sym_valid = 1'b0;
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (fifo_q.size() == 0 && cur_q.size() == 0 && !m_xv) begin
        idle = 1'b1;
        break;
      end
      step();
    end
    if (!idle) check_eq("drain_timeout", 32'd0, 32'd1);
  endtask

  // Compare observed bits to n expected bits (first emitted = pat[n-1]).
  task automatic check_seq(input string tag, input int n, input logic [31:0] pat);
    check_eq({tag, "_len"}, 32'(obs.size()), 32'(n));
    for (int i = 0; i < n && i < obs.size(); i++) begin
      check_eq($sformatf("%s_bit%0d", tag, i), 32'(obs[i]), 32'(pat[n-1-i]));
    end
    check_eq({tag, "_contig"}, 32'(last_cyc - first_cyc + 1), 32'(n));
  endtask

  initial begin
    int ones;
    reset     = 1'b1;
    sym_in    = 2'd0;
    sym_valid = 1'b0;
    pause     = 1'b0;
    @(posedge clk);
    #1;
    step();
    check_eq("rst_count", 32'(sym_count), 32'd0);
    check_eq("rst_xvalid", 32'(x_valid), 32'd0);
    reset = 1'b0;

    // 1: single symbol 2, latency 2 edges after the push edge
    clr_obs();
    push_sym(2);
    check_eq("t1_latency_idle", 32'(x_valid), 32'd0);
    step();
    check_eq("t1_latency_first", 32'(x_valid), 32'd1);
    drain();
    check_seq("t1", 3, 32'b110);
    check_eq("t1_count", 32'(sym_count), 32'd1);
    step();
    check_eq("t1_busy", 32'(busy), 32'd0);

    // 2: back-to-back 0,1,2,3
    clr_obs();
    for (int s = 0; s < 4; s++) push_sym(s);
    drain();
    check_seq("t2", 9, 32'b010110111);
    check_eq("t2_count", 32'(sym_count), 32'd5);

    // 3: fill while paused, 5th held until space frees
    clr_obs();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) push_sym(3);
    sym_valid = 1'b1;
    sym_in    = 2'd3;
    #1;
    check_eq("t3_full_ready", 32'(sym_ready), 32'd0);
    step();
    step();
    pause = 1'b0;
    push_sym(3);
    drain();
    check_seq("t3", 15, 32'h7fff);
    check_eq("t3_count", 32'(sym_count), 32'd10);

    // 4: pause 4 cycles after first bit of symbol 3
    clr_obs();
    push_sym(3);
    step();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t4_paused_xv", 32'(x_valid), 32'd0);
      check_eq("t4_paused_cnt", 32'(sym_count), 32'd10);
    end
    pause = 1'b0;
    drain();
    check_eq("t4_len", 32'(obs.size()), 32'd3);
    check_eq("t4_count", 32'(sym_count), 32'd11);

    // 5: reset mid-symbol drops everything
    clr_obs();
    for (int i = 0; i < 3; i++) push_sym(3);
    for (int t = 0; t < 50 && obs.size() < 5; t++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t5_xv", 32'(x_valid), 32'd0);
    check_eq("t5_count", 32'(sym_count), 32'd0);
    #1;
    check_eq("t5_busy", 32'(busy), 32'd0);
    clr_obs();
    for (int i = 0; i < 10; i++) step();
    check_eq("t5_no_bits", 32'(obs.size()), 32'd0);

    // 6: 256 zeros wrap the counter
    clr_obs();
    for (int i = 0; i < 256; i++) push_sym(0);
    drain();
    ones = 0;
    foreach (obs[i]) ones += int'(obs[i]);
    check_eq("t6_len", 32'(obs.size()), 32'd256);
    check_eq("t6_ones", 32'(ones), 32'd0);
    check_eq("t6_contig", 32'(last_cyc - first_cyc + 1), 32'd256);
    check_eq("t6_count_wrap", 32'(sym_count), 32'd0);

    // Random traffic with pauses and occasional resets
    for (int i = 0; i < 600; i++) begin
      sym_valid = ($urandom_range(0, 3) != 0);
      sym_in    = 2'($urandom_range(0, 3));
      pause     = ($urandom_range(0, 7) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    sym_valid = 1'b0;
    pause     = 1'b0;
    reset     = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/symbol_serializer.md
Name: symbol_serializer

Overview:
- Transmit end of the 3-bit-state serial decoder FSM: accepts 2-bit symbols through a valid/ready handshake.
- Buffers symbols in a small FIFO.
- Emits each symbol on the single-bit serial line `x` as a prefix code, one bit per clock, MSB first.
- Feeds the decoder's `x` input directly; that decoder samples only while `x_valid` is high.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the emitted-symbol counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- sym_in  input  2  symbol to send (0..3)
- sym_valid  input  1  sym_in is valid
- sym_ready  output  1  FIFO can accept; equals !full && !reset (combinational)
- pause  input  1  freezes the serializer; the FIFO still accepts
- x  output  1  serial bit (registered)
- x_valid  output  1  x carries a code bit this cycle (registered)
- busy  output  1  x_valid || FIFO non-empty (combinational)
- sym_count  output  CNT_W  symbols fully emitted, modulo 2^CNT_W (registered)

Behaviour:
- Reset values: x=0, x_valid=0, sym_count=0. FIFO is empty (rd/wr pointers = 0). Serializer is in IDLE with rem=0. sym_ready=0 during reset, then 1 on the first cycle after reset.
- Reset mid-symbol: the partial code is discarded and all queued symbols are dropped. No trailing bits follow reset.
- Prefix code, MSB first: 0 -> "0" (len 1); 1 -> "10" (len 2); 2 -> "110" (len 3); 3 -> "111" (len 3).
- Push: when sym_valid && sym_ready at an edge, sym_in is written at wr_ptr and wr_ptr increments.
- Full and empty are tracked with an extra pointer wrap bit or an occupancy counter (0..DEPTH).
- Push with sym_ready=0 is ignored; the sender must hold sym_valid.
- Serializer state: 3-bit register holding the shift pattern, plus rem (0..3). States are IDLE (rem=0) and SEND (rem>0).
- Each edge is evaluated in priority order:
  - reset: as above.
  - pause=1: x_valid<=0, x<=0; shift, rem and FIFO read side are frozen.
  - rem==0 and FIFO non-empty: pop the head symbol, drive its first code bit on x, x_valid<=1, rem<=len-1.
    - If len==1, the symbol completes at this edge: sym_count increments.
  - rem>0: shift out the next bit on x, x_valid<=1, rem<=rem-1.
    - When rem goes to 0, sym_count increments at this edge.
    - If rem==1 and the FIFO is non-empty, the pop happens at the next edge, so there is no gap between symbols.
  - otherwise: x_valid<=0, x<=0.
- Latency: symbol accepted at edge N (FIFO previously empty, serializer idle, pause=0) -> first code bit has x_valid=1 in the cycle following edge N+1.
- Back-to-back: with the FIFO kept non-empty, x_valid stays high continuously and symbol boundaries are contiguous.
- Simultaneous push and pop: legal whenever not full. Occupancy is unchanged; the pushed entry is never the one popped in the same edge unless it was already at the head.
- Full: sym_ready=0 even if a pop occurs that cycle (registered-full policy, no pass-through).
- Pause asserted mid-symbol: the remaining bits resume in order when pause drops. No bit is repeated or skipped. sym_count is unchanged while paused.
- Counter: sym_count wraps from 2^CNT_W-1 to 0.
- Pointers wrap modulo DEPTH.

Test Plan:
1. Reset, then push single symbol 2 in cycle 0, pause=0 -> x_valid high for exactly 3 cycles starting cycle 2 with x=1,1,0. sym_count=1 after the last bit. busy low afterwards.
2. Stream 0,1,2,3 back-to-back with valid held -> x=0,1,0,1,1,0,1,1,1 over 9 contiguous x_valid cycles, no gaps. sym_count=4.
3. Set pause=1, push 5 symbols of 3 with DEPTH=4 -> sym_ready drops after the 4th accept and the 5th is held. Release pause -> 12 bits of 1, then the 5th symbol's 3 bits; ready re-asserts.
4. Send symbol 3; assert pause for 4 cycles after its first bit -> x_valid=0 for those 4 cycles, then bits 1,1 resume. Total of three 1s; sym_count increments once.
5. Queue 3 symbols and assert reset after the 2nd bit of symbol 1 -> next cycle x_valid=0, sym_count=0, busy=0. No further bits appear without new pushes.
6. Push 256 symbols of 0 (CNT_W=8) -> sym_count returns to 0 after the 256th bit. x_valid high for 256 contiguous cycles.
